ram_access_ctrl: RTL and testbench

Initiator-side front end for the 4K x 32 synchronous RAM bank. It accepts single-beat write requests and incrementing-burst read requests over a valid/ready request channel, and drives the RAM pins (r_wn, address, data_in). Read data from the RAM's data_out comes back on a valid/ready response channel. It sits between the core's load/store logic and the RAM instance, so no other block ever drives r_wn directly.

---
 rtl/ram_ctrl_pkg.sv | 29 ++
 rtl/ram_rd_delay.sv | 38 +++
 rtl/ram_access_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ram_access_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ram_ctrl_pkg                                            |
// | Brief    : Shared constants and state encoding for the RAM access  |
// |            controller and its read-latency counter.                |
// | Options  : RAM_CTRL_WRITE_VERIFY_EN uses ST_VFY_WAIT.              |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 4;

  // RAM r_wn pin polarity
  localparam logic R_WN_READ  = 1'b1;
  localparam logic R_WN_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RSP      = 3'd4,
    ST_VFY_WAIT = 3'd5
  } ram_state_e;

endpackage
`default_nettype wire

// File: rtl/ram_rd_delay.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ram_rd_delay                                            |
// | Brief    : Loadable down-counter; done is high once RD_LAT-1 counts |
// |            have elapsed after load, marking valid RAM read data.   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module ram_rd_delay
  import ram_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] c_load_val = CNT_W'(RD_LAT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Reload on request, otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= c_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ram_access_ctrl                                         |
// | Brief    : Initiator front end for the 4K x 32 synchronous RAM:    |
// |            single-beat writes, incrementing-burst reads with a     |
// |            valid/ready response channel.                           |
// | Options  : RAM_CTRL_WRITE_VERIFY_EN adds read-back verification of |
// |            every write and the wr_err pulse output.                |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              ram_r_wn,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
`ifdef RAM_CTRL_WRITE_VERIFY_EN
  ,
  output logic              wr_err
`endif
);

  ram_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;      // doubles as the current beat address
  logic [DATA_W-1:0] r_wdata;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_valid;
  logic              r_rsp_last;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
  logic              r_wr_err;
`endif

  logic w_idle;
  logic w_accept;
  logic w_delay_load;
  logic w_delay_done;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && req_valid;

`ifdef RAM_CTRL_WRITE_VERIFY_EN
  // The write cycle also arms the counter for the verify read-back
  assign w_delay_load = (r_state == ST_RD_ISSUE) || (r_state == ST_WRITE);
`else
  assign w_delay_load = (r_state == ST_RD_ISSUE);
`endif

  ram_rd_delay #(
    .RD_LAT (RD_LAT)
  ) u_rd_delay (
    .clk  (clk),
    .rst  (rst),
    .load (w_delay_load),
    .done (w_delay_done)
  );

  // Request capture, beat sequencing and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
      r_wr_err    <= 1'b0;
`endif
    end else begin
`ifdef RAM_CTRL_WRITE_VERIFY_EN
      r_wr_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_len   <= req_len;
            r_beat  <= '0;
            r_state <= req_rd ? ST_RD_ISSUE : ST_WRITE;
          end
        end
        ST_WRITE: begin
`ifdef RAM_CTRL_WRITE_VERIFY_EN
          r_state <= ST_VFY_WAIT;
`else
          r_state <= ST_IDLE;
`endif
        end
        ST_RD_ISSUE: begin
          r_state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (w_delay_done) begin
            r_rsp_data  <= ram_data_out;
            r_rsp_valid <= 1'b1;
            r_rsp_last  <= (r_beat == r_len);
            r_state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          // Address and data stay frozen until the consumer takes the beat
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_rsp_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_addr  <= r_addr + ADDR_W'(1);
              r_beat  <= r_beat + LEN_W'(1);
              r_state <= ST_RD_ISSUE;
            end
          end
        end
`ifdef RAM_CTRL_WRITE_VERIFY_EN
        ST_VFY_WAIT: begin
          if (w_delay_done) begin
            r_wr_err <= (ram_data_out != r_wdata);
            r_state  <= ST_IDLE;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = w_idle;
  assign busy        = !w_idle;
  assign ram_r_wn    = (r_state == ST_WRITE) ? R_WN_WRITE : R_WN_READ;
  assign ram_address = r_addr;
  assign ram_data_in = r_wdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_last    = r_rsp_last;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
  assign wr_err      = r_wr_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_ram_access_ctrl                                      |
// | Brief    : Self-checking bench for ram_access_ctrl with a          |
// |            behavioural RAM and an array-based expected memory.     |
// | Options  : RAM_CTRL_WRITE_VERIFY_EN enables the wr_err checks.     |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_ram_access_ctrl;

  localparam int RD_LAT = 1;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
  localparam int WR_BUSY = 1 + RD_LAT;
`else
  localparam int WR_BUSY = 1;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rd;
  logic [11:0] req_addr;
  logic [3:0]  req_len;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        busy;
  logic        ram_r_wn;
  logic [11:0] ram_address;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
  logic        wr_err;
`endif

  ram_access_ctrl #(
    .ADDR_W (12),
    .DATA_W (32),
    .LEN_W  (4),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rd       (req_rd),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_last     (rsp_last),
    .busy         (busy),
    .ram_r_wn     (ram_r_wn),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    ,
    .wr_err       (wr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: write-first synchronous array, one cycle read latency
  logic [31:0] ram_mem [4096];
  logic [31:0] ram_q;
  logic        corrupt = 1'b0;
  always @(posedge clk) begin
    if (ram_r_wn == 1'b0) begin
      ram_mem[ram_address] <= ram_data_in;
      ram_q                <= ram_data_in;
    end else begin
      ram_q <= ram_mem[ram_address];
    end
  end
  assign ram_data_out = ram_q ^ {31'b0, corrupt};

  // Expected RAM contents, updated from issued write requests only
  logic [31:0] gold [4096];

  int n_vec  = 0;
  int n_fail = 0;

  int wr_lo_cnt = 0;
  always @(negedge clk) if (!rst && ram_r_wn === 1'b0) wr_lo_cnt <= wr_lo_cnt + 1;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
  int err_cnt = 0;
  always @(negedge clk) if (wr_err === 1'b1) err_cnt <= err_cnt + 1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request; returns at accept edge + 1
  task automatic send_req(input logic rd, input logic [11:0] a, input logic [3:0] l,
                          input logic [31:0] d);
    int w = 0;
    while (req_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_rd = rd; req_addr = a; req_len = l; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_rd    = 1'($urandom);
    req_addr  = 12'($urandom);
    req_len   = 4'($urandom);
    req_wdata = $urandom;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    int bc  = 0;
    int lo0 = wr_lo_cnt;
    send_req(1'b0, a, 4'd0, d);
    gold[a] = d;
    while (busy === 1'b1 && bc < 20) begin
      @(posedge clk); #1; bc++;
    end
    chk("wr_busy_cycles", 32'(bc), 32'(WR_BUSY));
    chk("wr_rwn_low", 32'(wr_lo_cnt - lo0), 32'd1);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall beat 1 for 3 cycles
  task automatic do_read(input logic [11:0] addr, input logic [3:0] len, input int mode);
    int          i = 0, cyc = 0, lat = 0, stall = 0;
    bit          first = 1'b1;
    logic        rdy;
    logic [11:0] ba;
    send_req(1'b1, addr, len, 32'h0);
    while (i <= int'(len) && cyc < 400) begin
      if (rsp_valid === 1'b1) begin
        if (first) begin
          chk("rd_first_latency", 32'(lat), 32'(RD_LAT + 1));
          first = 1'b0;
        end
        ba = addr + 12'(i);
        chk("rd_data", rsp_data, gold[ba]);
        chk("rd_last", 32'(rsp_last), 32'(i == int'(len)));
        chk("rd_addr", 32'(ram_address), 32'(ba));
        if (mode == 0)      rdy = 1'b1;
        else if (mode == 1) rdy = 1'($urandom_range(0, 1));
        else                rdy = !(i == 1 && stall < 3);
        if (!rdy) stall++;
        rsp_ready = rdy;
        @(posedge clk); #1;
        if (rdy) i++;
      end else begin
        rsp_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        if (first) lat++;
      end
      cyc++;
    end
    rsp_ready = 1'b1;
    chk("rd_beats", 32'(i), 32'(int'(len) + 1));
    chk("rd_idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int lo_t1, nv, cyc;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    int e0;
`endif
    rst = 1'b1; req_valid = 1'b0; req_rd = 1'b0; req_addr = '0; req_len = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_r_wn", 32'(ram_r_wn), 32'd1);
    chk("rst_address", 32'(ram_address), 32'd0);
    chk("rst_data_in", ram_data_in, 32'd0);
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    chk("rst_wr_err", 32'(wr_err), 32'd0);
`endif
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_req_ready", 32'(req_ready), 32'd1);

    // Two writes then a two-beat burst
    lo_t1 = wr_lo_cnt;
    do_write(12'h000, 32'habcd0123);
    do_write(12'h001, 32'hffeeddcc);
    do_read(12'h000, 4'd1, 0);
    chk("t1_rwn_low_total", 32'(wr_lo_cnt - lo_t1), 32'd2);

    // Overwrite, single-beat read
    do_write(12'h000, 32'h01234567);
    do_read(12'h000, 4'd0, 0);

    // Address wrap across the top of the array
    do_write(12'hFFF, 32'h11111111);
    do_write(12'h000, 32'h22222222);
    do_read(12'hFFF, 4'd1, 0);

    // Backpressure on beat 1
    for (int k = 0; k < 4; k++) do_write(12'h010 + 12'(k), 32'h5a000000 + 32'(k));
    do_read(12'h010, 4'd3, 2);

    // Random traffic in a preloaded window
    for (int k = 0; k < 64; k++) do_write(12'h100 + 12'(k), $urandom);
    do_read(12'h100, 4'd15, 0);
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) == 0)
        do_write(12'h100 + 12'($urandom_range(0, 63)), $urandom);
      else
        do_read(12'h100 + 12'($urandom_range(0, 48)), 4'($urandom_range(0, 15)), 1);
    end

    // Asynchronous reset during beat 2 of an 8-beat burst
    send_req(1'b1, 12'h100, 4'd7, 32'h0);
    rsp_ready = 1'b1;
    nv = 0; cyc = 0;
    while (nv < 3 && cyc < 100) begin
      if (rsp_valid === 1'b1) nv++;
      if (nv < 3) begin
        @(posedge clk); #1; cyc++;
      end
    end
    chk("rst_mid_reach_beat2", 32'(nv), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_r_wn", 32'(ram_r_wn), 32'd1);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    do_write(12'h005, 32'hcafef00d);
    do_read(12'h005, 4'd0, 0);

`ifdef RAM_CTRL_WRITE_VERIFY_EN
    // Corrupted read-back pulses wr_err once; a clean write does not
    e0 = err_cnt;
    corrupt = 1'b1;
    do_write(12'h0A5, 32'hdeadbeef);
    corrupt = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("vfy_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("vfy_err_low", 32'(wr_err), 32'd0);
    e0 = err_cnt;
    do_write(12'h0A6, 32'h12345678);
    repeat (3) begin @(posedge clk); #1; end
    chk("vfy_clean_pulses", 32'(err_cnt - e0), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
